// File: rtl/ctrl_hazard_pipe.sv
// Control-bundle pipeline after ID: per-stage valid bits, load-use bubble insertion,
// branch flush, global freeze and a saturating count of hazard bubbles.
module ctrl_hazard_pipe #(
    parameter int NUM_STAGES     = 3,
    parameter int ALU_OP_W       = 4,
    parameter int AM_W           = 2,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       id_valid,
    input  logic [ALU_OP_W-1:0]                        id_alu_op,
    input  logic [AM_W-1:0]                            id_am,
    input  logic                                       id_load,
    input  logic                                       id_mem_write,
    input  logic                                       id_store_cc,
    input  logic                                       id_b,
    input  logic                                       id_bl,
    input  logic                                       id_mem_size,
    input  logic                                       id_mem_e,
    input  logic                                       id_rf_e,
    input  logic [3:0]                                 id_rd,
    input  logic [3:0]                                 id_rn,
    input  logic [3:0]                                 id_rm,
    input  logic                                       id_uses_rn,
    input  logic                                       id_uses_rm,
    input  logic                                       flush,
    input  logic                                       ext_stall,
    output logic [NUM_STAGES*(ALU_OP_W+AM_W+12)-1:0]   stage_ctrl,
    output logic [NUM_STAGES-1:0]                      stage_valid,
    output logic                                       hazard_stall,
    output logic [15:0]                                bubble_count
);
    // state     | meaning
    // ST_RUN    | normal flow; load-use check active on the ID instruction
    // ST_LU_STALL | extra bubble cycles of a multi-cycle load-use stall
    localparam int BW    = ALU_OP_W + AM_W + 12;
    localparam int CNT_W = 3;
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_LU_STALL = 1'b1;
    localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_USE_STALL - 1);
    localparam logic [0:0] ST_AFTER_LU = (LOAD_USE_STALL > 1) ? ST_LU_STALL : ST_RUN;

    logic [NUM_STAGES-1:0][BW-1:0] ctrl_q, ctrl_d;
    logic [NUM_STAGES-1:0]         valid_q, valid_d;
    logic [0:0]                    state_q, state_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic [15:0]                   bubble_count_q, bubble_count_d;
    logic [BW-1:0]                 id_bundle;
    logic [BW-1:0]                 s0;
    logic                          load_use;
    logic                          stall_now;
    logic                          count_bubble;

    // BL writes the return address to r14, so the link write is forced here
    assign id_bundle = {id_alu_op, id_am, id_load, id_mem_write, id_store_cc, id_b, id_bl,
                        id_mem_size, id_mem_e, id_rf_e | id_bl, id_bl ? 4'd14 : id_rd};

    assign s0 = ctrl_q[0];
    assign load_use = id_valid & valid_q[0] & s0[11] & s0[4] &
                      ((id_uses_rn & (id_rn == s0[3:0])) | (id_uses_rm & (id_rm == s0[3:0])));

    always_comb begin
        ctrl_d         = ctrl_q;
        valid_d        = valid_q;
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        bubble_count_d = bubble_count_q;
        stall_now      = 1'b0;
        count_bubble   = 1'b0;
        if (ext_stall) begin
            stall_now = 1'b1;
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                ctrl_d[k]  = ctrl_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            ctrl_d[0]  = '0;
            valid_d[0] = 1'b0;
            if (flush) begin
                state_d     = ST_RUN;
                stall_cnt_d = '0;
            end else if (state_q == ST_LU_STALL) begin
                stall_now    = 1'b1;
                count_bubble = 1'b1;
                stall_cnt_d  = stall_cnt_q - 1'b1;
                if (stall_cnt_q <= 1) state_d = ST_RUN;
            end else if (load_use) begin
                stall_now    = 1'b1;
                count_bubble = 1'b1;
                stall_cnt_d  = STALL_RELOAD;
                state_d      = ST_AFTER_LU;
            end else if (id_valid) begin
                ctrl_d[0]  = id_bundle;
                valid_d[0] = 1'b1;
            end
            if (count_bubble && (bubble_count_q != 16'hFFFF))
                bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q         <= '0;
            valid_q        <= '0;
            state_q        <= ST_RUN;
            stall_cnt_q    <= '0;
            bubble_count_q <= '0;
        end else begin
            ctrl_q         <= ctrl_d;
            valid_q        <= valid_d;
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stage_ctrl   = ctrl_q;
    assign stage_valid  = valid_q;
    assign hazard_stall = rst_n & stall_now;
    assign bubble_count = bubble_count_q;
endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Bench for ctrl_hazard_pipe: two instances (1- and 2-cycle load-use stall) share stimulus
// and are compared every cycle against a queue-style pipeline model, plus literal pins.
module tb_ctrl_hazard_pipe;
    localparam int NS = 3;
    localparam int AW = 4;
    localparam int MW = 2;
    localparam int BW = AW + MW + 12;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_load, id_mem_write, id_store_cc, id_b, id_bl, id_mem_size, id_mem_e, id_rf_e;
    logic [AW-1:0] id_alu_op;
    logic [MW-1:0] id_am;
    logic [3:0] id_rd, id_rn, id_rm;
    logic id_uses_rn, id_uses_rm, flush, ext_stall;

    logic [NS*BW-1:0] sc1, sc2;
    logic [NS-1:0]    sv1, sv2;
    logic             hs1, hs2;
    logic [15:0]      bc1, bc2;

    int checks, failures;

    logic [BW-1:0] m_ctrl [2][NS];
    logic          m_valid [2][NS];
    int            m_rem [2];
    int            m_bc [2];
    int            lus [2] = '{1, 2};

    always #5 clk = ~clk;

    ctrl_hazard_pipe #(.NUM_STAGES(NS), .ALU_OP_W(AW), .AM_W(MW), .LOAD_USE_STALL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_am(id_am),
        .id_load(id_load), .id_mem_write(id_mem_write), .id_store_cc(id_store_cc), .id_b(id_b),
        .id_bl(id_bl), .id_mem_size(id_mem_size), .id_mem_e(id_mem_e), .id_rf_e(id_rf_e),
        .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .flush(flush), .ext_stall(ext_stall), .stage_ctrl(sc1), .stage_valid(sv1),
        .hazard_stall(hs1), .bubble_count(bc1));

    ctrl_hazard_pipe #(.NUM_STAGES(NS), .ALU_OP_W(AW), .AM_W(MW), .LOAD_USE_STALL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_am(id_am),
        .id_load(id_load), .id_mem_write(id_mem_write), .id_store_cc(id_store_cc), .id_b(id_b),
        .id_bl(id_bl), .id_mem_size(id_mem_size), .id_mem_e(id_mem_e), .id_rf_e(id_rf_e),
        .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .flush(flush), .ext_stall(ext_stall), .stage_ctrl(sc2), .stage_valid(sv2),
        .hazard_stall(hs2), .bubble_count(bc2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] exp_bundle();
        logic [3:0] rd;
        logic       rf;
        rd = id_bl ? 4'd14 : id_rd;
        rf = id_rf_e | id_bl;
        return {id_alu_op, id_am, id_load, id_mem_write, id_store_cc, id_b, id_bl,
                id_mem_size, id_mem_e, rf, rd};
    endfunction

    // Load-use: the instruction in ID reads the register a load in stage 0 will write
    function automatic logic m_lu(input int d);
        logic [BW-1:0] s;
        logic [3:0]    dst;
        s   = m_ctrl[d][0];
        dst = s[3:0];
        if (!(id_valid && m_valid[d][0] && s[11] && s[4])) return 1'b0;
        return (id_uses_rn && id_rn == dst) || (id_uses_rm && id_rm == dst);
    endfunction

    function automatic logic m_hs(input int d);
        if (!rst_n) return 1'b0;
        if (ext_stall) return 1'b1;
        if (flush) return 1'b0;
        if (m_rem[d] > 0) return 1'b1;
        return m_lu(d);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NS; k++) begin
                m_ctrl[d][k]  = '0;
                m_valid[d][k] = 1'b0;
            end
            m_rem[d] = 0;
            m_bc[d]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic lu;
            lu = m_lu(d);
            if (!ext_stall) begin
                for (int k = NS - 1; k > 0; k--) begin
                    m_ctrl[d][k]  = m_ctrl[d][k-1];
                    m_valid[d][k] = m_valid[d][k-1];
                end
                m_ctrl[d][0]  = '0;
                m_valid[d][0] = 1'b0;
                if (flush) begin
                    m_rem[d] = 0;
                end else if (m_rem[d] > 0) begin
                    m_rem[d]--;
                    if (m_bc[d] < 65535) m_bc[d]++;
                end else if (lu) begin
                    m_rem[d] = lus[d] - 1;
                    if (m_bc[d] < 65535) m_bc[d]++;
                end else if (id_valid) begin
                    m_ctrl[d][0]  = exp_bundle();
                    m_valid[d][0] = 1'b1;
                end
            end
        end
        if (!rst_n) model_reset();
    endtask

    task automatic cmp_all();
        for (int d = 0; d < 2; d++) begin
            logic [NS*BW-1:0] e_sc;
            logic [NS-1:0]    e_sv;
            for (int k = 0; k < NS; k++) begin
                e_sc[k*BW +: BW] = m_ctrl[d][k];
                e_sv[k]          = m_valid[d][k];
            end
            check($sformatf("dut%0d stage_ctrl", d + 1), 64'(d == 0 ? sc1 : sc2), 64'(e_sc));
            check($sformatf("dut%0d stage_valid", d + 1), 64'(d == 0 ? sv1 : sv2), 64'(e_sv));
            check($sformatf("dut%0d hazard_stall", d + 1), 64'(d == 0 ? hs1 : hs2), 64'(m_hs(d)));
            check($sformatf("dut%0d bubble_count", d + 1), 64'(d == 0 ? bc1 : bc2), 64'(m_bc[d]));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_alu_op = '0; id_am = '0; id_load = 0; id_mem_write = 0; id_store_cc = 0;
        id_b = 0; id_bl = 0; id_mem_size = 0; id_mem_e = 0; id_rf_e = 0; id_rd = '0;
        id_rn = '0; id_rm = '0; id_uses_rn = 0; id_uses_rm = 0;
    endtask

    task automatic set_add(input logic [3:0] rd);
        clear_id();
        id_valid = 1; id_alu_op = 4'b0100; id_rf_e = 1; id_rd = rd;
    endtask

    task automatic set_ldr(input logic [3:0] rd);
        clear_id();
        id_valid = 1; id_load = 1; id_mem_e = 1; id_rf_e = 1; id_rd = rd;
    endtask

    task automatic do_reset();
        clear_id();
        flush = 0; ext_stall = 0;
        rst_n = 0;
        model_reset();
        cycle();
        rst_n = 1;
    endtask

    initial begin
        checks = 0; failures = 0;
        clear_id(); flush = 0; ext_stall = 0;
        rst_n = 0;
        model_reset();
        #1;
        check("reset stage_ctrl", 64'(sc1), 64'h0);
        check("reset hazard_stall", 64'(hs1), 64'h0);
        repeat (2) cycle();
        rst_n = 1;

        // straight-line ADDs
        set_add(4'd1); cycle();
        set_add(4'd2); cycle();
        set_add(4'd3); cycle();
        check("add stage2 bundle", 64'(sc1[2*BW +: BW]), 64'h10011);
        check("add stage_valid", 64'(sv1), 64'h7);
        check("add bubble_count", 64'(bc1), 64'h0);
        clear_id(); repeat (3) cycle();

        // load-use with 1 and 2 bubble cycles
        do_reset();
        set_ldr(4'd4); cycle();
        set_add(4'd5); id_rn = 4'd4; id_uses_rn = 1; #1;
        check("lu hs1 first", 64'(hs1), 64'h1);
        check("lu hs2 first", 64'(hs2), 64'h1);
        cycle();
        check("lu1 s0 bubble", 64'(sv1[0]), 64'h0);
        check("lu2 s0 bubble", 64'(sv2[0]), 64'h0);
        check("lu1 hs released", 64'(hs1), 64'h0);
        check("lu2 hs second", 64'(hs2), 64'h1);
        check("lu1 count", 64'(bc1), 64'h1);
        cycle();
        check("lu1 add captured", 64'(sc1[BW-1:0]), 64'h10015);
        check("lu1 valid", 64'(sv1), 64'h5);
        check("lu2 valid", 64'(sv2), 64'h4);
        check("lu2 count", 64'(bc2), 64'h2);
        check("lu2 hs released", 64'(hs2), 64'h0);
        cycle();
        check("lu2 add captured", 64'(sv2[0]), 64'h1);
        check("lu1 count final", 64'(bc1), 64'h1);
        clear_id(); repeat (3) cycle();

        // flush aborts the second stall cycle
        do_reset();
        set_ldr(4'd4); cycle();
        set_add(4'd5); id_rn = 4'd4; id_uses_rn = 1; cycle();
        flush = 1; #1;
        check("flush hs2", 64'(hs2), 64'h0);
        cycle();
        check("flush count2", 64'(bc2), 64'h1);
        check("flush s0", 64'(sv2[0]), 64'h0);
        flush = 0; #1;
        check("after flush hs2", 64'(hs2), 64'h0);
        clear_id(); repeat (3) cycle();

        // external freeze with a full pipe
        do_reset();
        set_add(4'd1); cycle();
        set_add(4'd2); cycle();
        set_add(4'd3); cycle();
        set_add(4'd7); ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("freeze ctrl", 64'(sc1), 64'({18'h10011, 18'h10012, 18'h10013}));
            check("freeze valid", 64'(sv1), 64'h7);
            check("freeze hs", 64'(hs1), 64'h1);
        end
        ext_stall = 0; cycle();
        check("resume ctrl", 64'(sc1), 64'({18'h10012, 18'h10013, 18'h10017}));
        clear_id(); repeat (3) cycle();

        // BL link write
        do_reset();
        clear_id(); id_valid = 1; id_bl = 1; id_rd = 4'd0; cycle();
        check("bl bundle", 64'(sc1[BW-1:0]), 64'h0009E);

        // reset asserted in the middle of a load-use stall
        clear_id(); cycle();
        set_ldr(4'd4); cycle();
        set_add(4'd5); id_rn = 4'd4; id_uses_rn = 1; cycle();
        #1 rst_n = 0; model_reset();
        #1;
        check("async rst ctrl2", 64'(sc2), 64'h0);
        check("async rst valid2", 64'(sv2), 64'h0);
        check("async rst count2", 64'(bc2), 64'h0);
        check("async rst hs2", 64'(hs2), 64'h0);
        cycle();
        rst_n = 1;
        cycle();
        check("post rst capture", 64'(sv2[0]), 64'h1);
        clear_id(); repeat (3) cycle();

        // randomized traffic with small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_alu_op    = 4'($urandom);
            id_am        = 2'($urandom);
            id_load      = 1'($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom_range(0, 1));
            id_store_cc  = 1'($urandom_range(0, 1));
            id_b         = 1'($urandom_range(0, 1));
            id_bl        = 1'($urandom_range(0, 7) == 0);
            id_mem_size  = 1'($urandom_range(0, 1));
            id_mem_e     = 1'($urandom_range(0, 1));
            id_rf_e      = 1'($urandom_range(0, 3) != 0);
            id_rd        = 4'($urandom_range(0, 3));
            id_rn        = ($urandom_range(0, 9) == 0) ? 4'd14 : 4'($urandom_range(0, 3));
            id_rm        = 4'($urandom_range(0, 3));
            id_uses_rn   = 1'($urandom_range(0, 1));
            id_uses_rm   = 1'($urandom_range(0, 1));
            flush        = 1'($urandom_range(0, 9) == 0);
            ext_stall    = 1'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            cycle();
        end
        rst_n = 1; clear_id(); flush = 0; ext_stall = 0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
